// File: rtl/flash_loader.sv
// Boot-time SPI flash reader: READ + 24-bit address, packs bytes little-endian into 32-bit RAM words.
// Define FLASH_LOADER_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks.
module flash_loader #(
  parameter int unsigned AddressBitWidth    = 24,
  parameter int unsigned RamAddressBitWidth = 32,
  parameter int unsigned CountBitWidth      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [AddressBitWidth-1:0]    flash_address,
  input  logic [RamAddressBitWidth-1:0] ram_address,
  input  logic [CountBitWidth-1:0]      word_count,
  output logic                          busy,
  output logic                          done,
  output logic                          flash_clk,
  output logic                          flash_cs,
  output logic                          flash_mosi,
  input  logic                          flash_miso,
  output logic                          ram_we,
  output logic [RamAddressBitWidth-1:0] ram_addr,
  output logic [31:0]                   ram_data,
  input  logic                          ram_ready
);

`ifdef FLASH_LOADER_FAST_READ_EN
  localparam logic [7:0] ReadCmd = 8'h0B;
`else
  localparam logic [7:0] ReadCmd = 8'h03;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StSendCommand,
    StSendAddress,
    StSendDummy,
    StReceiveData,
    StWriteWord,
    StFinish
  } state_e;

  state_e                        state_q, state_d;
  logic                          phase_q, phase_d;
  logic [4:0]                    bit_cnt_q, bit_cnt_d;
  logic [31:0]                   tx_q, tx_d;
  logic [31:0]                   rx_q, rx_d;
  logic [CountBitWidth-1:0]      count_q, count_d;
  logic [RamAddressBitWidth-1:0] addr_q, addr_d;
  logic [31:0]                   data_q, data_d;
  logic [4:0]                    last_bit;

  always_comb begin
    last_bit = 5'd0;
    case (state_q)
      StSendCommand: last_bit = 5'd7;
      StSendAddress: last_bit = 5'd23;
      StSendDummy:   last_bit = 5'd7;
      StReceiveData: last_bit = 5'd31;
      default:       last_bit = 5'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    count_d   = count_q;
    addr_d    = addr_q;
    data_d    = data_q;
    unique case (state_q)
      StIdle: begin
        phase_d = 1'b0;
        if (start) begin
          addr_d    = ram_address;
          count_d   = word_count;
          bit_cnt_d = 5'd0;
          if (word_count == '0) begin
            state_d = StFinish;
          end else begin
            tx_d    = {ReadCmd, flash_address};
            state_d = StSendCommand;
          end
        end
      end
      StSendCommand, StSendAddress, StSendDummy, StReceiveData: begin
        phase_d = ~phase_q;
        // phase_q high: this edge ends SCK-high, so sample MISO and advance MOSI
        if (phase_q) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          tx_d      = {tx_q[30:0], 1'b0};
          rx_d      = {rx_q[30:0], flash_miso};
          if (bit_cnt_q == last_bit) begin
            bit_cnt_d = 5'd0;
            if (state_q == StSendCommand) begin
              state_d = StSendAddress;
            end else if (state_q == StSendAddress) begin
`ifdef FLASH_LOADER_FAST_READ_EN
              state_d = StSendDummy;
`else
              state_d = StReceiveData;
`endif
            end else if (state_q == StSendDummy) begin
              state_d = StReceiveData;
            end else begin
              state_d = StWriteWord;
              data_d  = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};
            end
          end
        end
      end
      StWriteWord: begin
        phase_d = 1'b0;
        if (ram_ready) begin
          addr_d  = addr_q + RamAddressBitWidth'(1);
          count_d = count_q - CountBitWidth'(1);
          state_d = (count_q == CountBitWidth'(1)) ? StFinish : StReceiveData;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      phase_q   <= 1'b0;
      bit_cnt_q <= 5'd0;
      tx_q      <= '0;
      rx_q      <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  // phase_q is forced low outside shifting states, so SCK comes straight from a flop
  assign flash_clk  = phase_q;
  assign flash_mosi = tx_q[31];
  assign flash_cs   = (state_q == StIdle) || (state_q == StFinish);
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFinish);
  assign ram_we     = (state_q == StWriteWord);
  assign ram_addr   = addr_q;
  assign ram_data   = data_q;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader with a behavioural SPI flash holding byte value == address[7:0].
module tb_flash_loader;

`ifdef FLASH_LOADER_FAST_READ_EN
  localparam int unsigned HdrBits    = 40;
  localparam logic [7:0]  ExpCmd     = 8'h0B;
  localparam int          ExpFirstWe = 145;
`else
  localparam int unsigned HdrBits    = 32;
  localparam logic [7:0]  ExpCmd     = 8'h03;
  localparam int          ExpFirstWe = 129;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] flash_address = '0;
  logic [31:0] ram_address = '0;
  logic [15:0] word_count = '0;
  logic        busy, done, flash_clk, flash_cs, flash_mosi, ram_we;
  logic        flash_miso = 1'b0;
  logic [31:0] ram_addr, ram_data;
  logic        ram_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flash_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flash_address(flash_address),
    .ram_address  (ram_address),
    .word_count   (word_count),
    .busy         (busy),
    .done         (done),
    .flash_clk    (flash_clk),
    .flash_cs     (flash_cs),
    .flash_mosi   (flash_mosi),
    .flash_miso   (flash_miso),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_ready    (ram_ready)
  );

  // Flash model: capture command/address on SCK rise, drive data on SCK fall.
  int unsigned fm_bits = 0;
  logic [31:0] fm_hdr = '0;
  int unsigned fm_n = 0;
  logic [7:0]  fm_byte = '0;
`ifdef FLASH_LOADER_FAST_READ_EN
  logic [7:0]  fm_dummy = '0;
`endif

  always @(posedge flash_clk or posedge flash_cs) begin
    if (flash_cs) begin
      fm_bits = 0;
    end else begin
      if (fm_bits < 32) fm_hdr = {fm_hdr[30:0], flash_mosi};
`ifdef FLASH_LOADER_FAST_READ_EN
      else if (fm_bits < HdrBits) fm_dummy = {fm_dummy[6:0], flash_mosi};
`endif
      fm_bits++;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_cs && fm_bits >= HdrBits) begin
      fm_n       = fm_bits - HdrBits;
      fm_byte    = fm_hdr[7:0] + 8'(fm_n / 8);
      flash_miso = fm_byte[3'(7 - (fm_n % 8))];
    end
  end

  // Monitor: statistics restart at every accepted start.
  int          cyc = 0;
  int          start_cyc = 0;
  int          first_we_cyc = -1;
  int          done_cyc = 0;
  int          wr_n = 0;
  int          done_n = 0;
  logic        cs_low_seen = 1'b0;
  logic [31:0] wr_addr [4];
  logic [31:0] wr_data [4];
  int          wr_cyc  [4];

  always @(negedge clk) begin
    cyc++;
    if (start && !busy) begin
      start_cyc    = cyc;
      first_we_cyc = -1;
      wr_n         = 0;
      done_n       = 0;
      cs_low_seen  = 1'b0;
    end
    if (ram_we && first_we_cyc < 0) first_we_cyc = cyc;
    if (ram_we && ram_ready && wr_n < 4) begin
      wr_addr[wr_n] = ram_addr;
      wr_data[wr_n] = ram_data;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (!flash_cs) cs_low_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic [23:0] fa, input logic [31:0] ra, input logic [15:0] wc);
    @(posedge clk);
    #1;
    flash_address = fa;
    ram_address   = ra;
    word_count    = wc;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_two_words(input string tag, input logic [31:0] base);
    check_eq({tag, "_wr_n"}, 32'(wr_n), 32'd2);
    check_eq({tag, "_addr0"}, wr_addr[0], base);
    check_eq({tag, "_data0"}, wr_data[0], 32'h0302_0100);
    check_eq({tag, "_addr1"}, wr_addr[1], base + 32'd1);
    check_eq({tag, "_data1"}, wr_data[1], 32'h0706_0504);
    check_eq({tag, "_done_n"}, 32'(done_n), 32'd1);
    check_eq({tag, "_cs_after"}, 32'(flash_cs), 32'd1);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic        stable;
    logic [31:0] a0, d0;
    logic        seen;

    // Reset values
    #12;
    check_eq("rst_cs", 32'(flash_cs), 32'd1);
    check_eq("rst_sck", 32'(flash_clk), 32'd0);
    check_eq("rst_mosi", 32'(flash_mosi), 32'd0);
    check_eq("rst_busy_done_we", {29'd0, busy, done, ram_we}, 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'd0);
    check_eq("rst_ram_data", ram_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic two-word copy with timing
    kick(24'h000000, 32'h100, 16'd2);
    wait_done("a_done");
    check_two_words("a", 32'h100);
    check_eq("a_hdr", fm_hdr, {ExpCmd, 24'h000000});
    check_eq("a_first_we_lat", 32'(first_we_cyc - start_cyc), 32'(ExpFirstWe));
    check_eq("a_word_period", 32'(wr_cyc[1] - wr_cyc[0]), 32'd65);
    check_eq("a_done_lat", 32'(done_cyc - wr_cyc[1]), 32'd1);
`ifdef FLASH_LOADER_FAST_READ_EN
    check_eq("a_dummy_bits", 32'(fm_dummy), 32'd0);
`endif

    // MOSI header capture and nonzero flash address
    kick(24'h123456, 32'h200, 16'd1);
    wait_done("m_done");
    check_eq("m_hdr", fm_hdr, {ExpCmd, 24'h123456});
    check_eq("m_wr_n", 32'(wr_n), 32'd1);
    check_eq("m_addr0", wr_addr[0], 32'h200);
    check_eq("m_data0", wr_data[0], 32'h5958_5756);

    // Back-pressure on first word
    ram_ready = 1'b0;
    kick(24'h000000, 32'h300, 16'd2);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (ram_we) seen = 1'b1;
    end
    check_eq("s_we_seen", 32'(seen), 32'd1);
    a0 = ram_addr;
    d0 = ram_data;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_addr !== a0 || ram_data !== d0 || ram_we !== 1'b1 || flash_clk !== 1'b0 ||
          flash_cs !== 1'b0) stable = 1'b0;
    end
    check_eq("s_stable", 32'(stable), 32'd1);
    check_eq("s_hold_addr", a0, 32'h300);
    check_eq("s_hold_data", d0, 32'h0302_0100);
    @(posedge clk);
    #1;
    ram_ready = 1'b1;
    wait_done("s_done");
    check_two_words("s", 32'h300);
    check_eq("s_stall_len", 32'(wr_cyc[0] - first_we_cyc), 32'd11);

    // Zero-length request
    kick(24'h000010, 32'h400, 16'd0);
    wait_done("z_done");
    check_eq("z_done_n", 32'(done_n), 32'd1);
    check_eq("z_wr_n", 32'(wr_n), 32'd0);
    check_eq("z_cs_low", 32'(cs_low_seen), 32'd0);
    check_eq("z_done_lat", 32'(done_cyc - start_cyc), 32'd1);
    check_eq("z_busy_after", 32'(busy), 32'd0);

    // Asynchronous reset during address phase, then recovery
    kick(24'h000000, 32'h500, 16'd1);
    repeat (30) @(negedge clk);
    check_eq("r_cs_before", 32'(flash_cs), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("r_cs", 32'(flash_cs), 32'd1);
    check_eq("r_sck_mosi", {30'd0, flash_clk, flash_mosi}, 32'd0);
    check_eq("r_busy_done_we", {29'd0, busy, done, ram_we}, 32'd0);
    check_eq("r_ram_addr", ram_addr, 32'd0);
    check_eq("r_ram_data", ram_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    kick(24'h000000, 32'h100, 16'd2);
    wait_done("r2_done");
    check_two_words("r2", 32'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
- Boot-time SPI flash read master that sits directly upstream of the P25Q32U flash device (or its simulation model).
- On start, issues READ (0x03) plus a 24-bit address and streams in a block of bytes.
- Packs the bytes little-endian into 32-bit words and writes them to RAM through a valid/ready write port.
- Signals done when the block is copied; the core is held in reset until then.

Parameters:
- AddressBitWidth, 24, width of flash byte address (fixed to the 24 bits sent on the wire).
- RamAddressBitWidth, 32, width of RAM word-write address.
- CountBitWidth, 16, width of the word-count input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; sampled only in Idle.
- flash_address  input  24  first flash byte address.
- ram_address  input  RamAddressBitWidth  first RAM word address.
- word_count  input  CountBitWidth  number of 32-bit words to copy; 0 means none.
- busy  output  1  high from start accept until return to Idle.
- done  output  1  one-cycle pulse on completion.
- flash_clk  output  1  SPI SCK, mode 0, = clk/2.
- flash_cs  output  1  chip select, active low.
- flash_mosi  output  1  serial data to flash.
- flash_miso  input  1  serial data from flash.
- ram_we  output  1  word-write valid.
- ram_addr  output  RamAddressBitWidth  word-write address.
- ram_data  output  32  word-write data.
- ram_ready  input  1  RAM accepts the write when ram_we && ram_ready.

Behaviour:
- Reset values (asynchronous, immediate): flash_cs=1, flash_clk=0, flash_mosi=0, busy=0, done=0, ram_we=0, ram_addr=0, ram_data=0; state Idle.
- Reset mid-transfer aborts; the RAM write in flight is dropped.
- SPI bit timing: each bit is 2 clk cycles.
  - Phase L: flash_clk=0; mosi updated.
  - Phase H: flash_clk=1; miso sampled into the shift register on the clk edge that ends phase H.
  - MSB first. flash_cs is low for the whole transaction.
- State Idle: on start, latch inputs, set busy=1.
  - If word_count==0: go to Finish directly; done still pulses, busy drops the next cycle, flash_cs never asserts.
  - Otherwise: flash_cs=0, go to SendCommand.
- State SendCommand: shift out 8 bits of 0x03 (16 clk), then go to SendAddress.
- State SendAddress: shift out 24 address bits MSB first (48 clk), then go to ReceiveData.
- State ReceiveData: shift in 32 bits (64 clk).
  - Byte k of the word (k=0 first received) lands in ram_data[8k+7:8k].
  - After bit 32: ram_we=1, ram_addr=current word address, go to WriteWord.
- State WriteWord: flash_clk held 0, cs held low (SPI clock pause).
  - When ram_ready: ram_we=0 next cycle, word address +1, remaining count -1.
  - If remaining count is now 0: go to Finish. Otherwise go to ReceiveData.
  - ram_ready may already be high the cycle ram_we rises; the write then completes in 1 cycle.
- State Finish: flash_cs=1, done=1 for one cycle, busy=0 next cycle, return to Idle.
- start while busy is ignored.
- Flash address wrap above 0xFFFFFF is the device's concern (no special handling). RAM address wraps modulo 2^RamAddressBitWidth.
- Latency, word_count=N (ram_ready always high): start to first ram_we = 1+16+48+64 cycles; subsequent words every 65 cycles; done 1 cycle after the last accept.

Optional Feature:
- Macro FLASH_LOADER_FAST_READ_EN.
- Defined: command 0x0B; after the address, state SendDummy clocks 8 dummy bits (mosi=0, 16 clk) before ReceiveData; first ram_we is 16 cycles later.
- Undefined: plain READ 0x03, no dummy state.

Test Plan:
- Flash model preloaded 00..FF; start with flash_address=0, ram_address=0x100, word_count=2 -> writes 0x100:0x03020100 and 0x101:0x07060504; done pulses once; flash_cs high after.
- Mosi capture on start with flash_address=0x123456 -> first 32 bits on flash_mosi = 0x03123456, sampled on flash_clk rising edges.
- ram_ready held low 10 cycles on the first word -> ram_we/ram_addr/ram_data stable, flash_clk static at 0, flash_cs low; the second word is still 0x07060504.
- word_count=0 -> done pulses, flash_cs never goes low, no ram_we.
- rst_n low during SendAddress -> all outputs at reset values immediately; new start afterwards completes a correct transfer.
- FLASH_LOADER_FAST_READ_EN defined -> command byte 0x0B, 8 dummy clocks, same RAM data as the first scenario.
